// File: rtl/ob_pkg.sv
// ob_pkg: shared order-book types used by the per-side table scheduler.
//   table_t         : one book entry {uid, price, qty}
//   sched_ing_op_t  : ingress command (insert / cancel)
//   sched_mch_op_t  : match-engine head operation (pop / push / replace)
//   sched_state_t   : scheduler FSM states
package ob_pkg;

  localparam int UID_W   = 8;
  localparam int PRICE_W = 16;
  localparam int QTY_W   = 16;
  localparam int TBL_W   = UID_W + PRICE_W + QTY_W;

  typedef logic [UID_W-1:0] uid_t;

  typedef struct packed {
    uid_t               uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } table_t;

  typedef enum logic {
    ING_INSERT = 1'b0,
    ING_CANCEL = 1'b1
  } sched_ing_op_t;

  typedef enum logic [1:0] {
    MCH_POP     = 2'd0,
    MCH_PUSH    = 2'd1,
    MCH_REPLACE = 2'd2
  } sched_mch_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REPL   = 2'd1,
    S_SETTLE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/ob_tbl_sched.sv
// ob_tbl_sched: per-side scheduler for one order-book table (bid or ask).
// Grants at most one table modification per cycle, arbitrating between the
// ingress path (insert/cancel) and the match engine (pop/push/replace of the
// head). Replace is sequenced as pop then push; cancel results come back on a
// registered valid/ready response port.
// Ports:
//   ing_*   : ingress request (vld/rdy, op, insert entry, cancel uid)
//   mch_*   : match-engine request (vld/rdy, op, entry for push/replace)
//   rsp_*   : cancel response (vld/rdy, hit, cancelled entry)
//   tbl_*   : strobes/payloads to the table, *_w status back from the table
//   busy    : FSM not idle or a response is pending
module ob_tbl_sched
  import ob_pkg::*;
#(
  parameter int AGE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ing_vld,
  output logic             ing_rdy,
  input  logic             ing_op,
  input  logic [TBL_W-1:0] ing_tbl,
  input  logic [UID_W-1:0] ing_uid,
  input  logic             mch_vld,
  output logic             mch_rdy,
  input  logic [1:0]       mch_op,
  input  logic [TBL_W-1:0] mch_tbl,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic             rsp_hit,
  output logic [TBL_W-1:0] rsp_tbl,
  output logic             tbl_insert,
  output logic [TBL_W-1:0] tbl_insert_tbl,
  output logic             tbl_cancel,
  output logic [UID_W-1:0] tbl_cancel_uid,
  output logic             tbl_head_pop,
  output logic             tbl_head_push,
  output logic [TBL_W-1:0] tbl_head_push_tbl,
  input  logic             tbl_cancel_hit_w,
  input  logic [TBL_W-1:0] tbl_cancel_hit_tbl_w,
  input  logic             tbl_full_w,
  input  logic             tbl_empty_w,
  output logic             busy
);

  // AGE_MAX=0 still needs a 1-bit counter; it simply never leaves zero.
  localparam int AGE_W = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

  sched_state_t     state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             full_q, empty_q;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [TBL_W-1:0] rsp_tbl_q, rsp_tbl_d;
  logic [TBL_W-1:0] repl_tbl_q, repl_tbl_d;
  // Holds every grant low while in reset and for the first cycle after it.
  logic             run_q;

  sched_ing_op_t    ing_op_s;
  sched_mch_op_t    mch_op_s;
  logic             ing_ok, mch_ok, age_win;

  assign ing_op_s = sched_ing_op_t'(ing_op);
  assign mch_op_s = sched_mch_op_t'(mch_op);

  // Eligibility of each requester, independent of arbitration.
  always_comb begin
    ing_ok = 1'b0;
    mch_ok = 1'b0;
    if (ing_op_s == ING_INSERT) begin
      ing_ok = ing_vld & ~full_q;
    end else begin
      ing_ok = ing_vld & (~rsp_vld_q | rsp_rdy);
    end
    case (mch_op_s)
      MCH_POP:     mch_ok = mch_vld & ~empty_q;
      MCH_PUSH:    mch_ok = mch_vld & ~full_q;
      MCH_REPLACE: mch_ok = mch_vld & ~empty_q;
      default:     mch_ok = 1'b0;
    endcase
    age_win = (age_q == AGE_LIM);
  end

  // Arbitration, FSM next state, table strobes and response register update.
  always_comb begin
    state_d           = state_q;
    age_d             = age_q;
    rsp_vld_d         = rsp_vld_q;
    rsp_hit_d         = rsp_hit_q;
    rsp_tbl_d         = rsp_tbl_q;
    repl_tbl_d        = repl_tbl_q;
    ing_rdy           = 1'b0;
    mch_rdy           = 1'b0;
    tbl_insert        = 1'b0;
    tbl_insert_tbl    = '0;
    tbl_cancel        = 1'b0;
    tbl_cancel_uid    = '0;
    tbl_head_pop      = 1'b0;
    tbl_head_push     = 1'b0;
    tbl_head_push_tbl = '0;

    case (state_q)
      S_IDLE: begin
        // Match has priority unless a starved ingress has aged out.
        if (mch_ok && !(age_win && ing_ok)) begin
          mch_rdy = run_q;
        end else begin
          ing_rdy = ing_ok & run_q;
        end
      end
      S_REPL: begin
        // Second half of replace: atomic, nobody else touches the table.
        tbl_head_push     = 1'b1;
        tbl_head_push_tbl = repl_tbl_q;
        state_d           = S_SETTLE;
      end
      S_SETTLE: begin
        // Table head register is still updating; only ingress may go.
        ing_rdy = ing_ok & run_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (mch_rdy) begin
      case (mch_op_s)
        MCH_POP: begin
          tbl_head_pop = 1'b1;
          state_d      = S_SETTLE;
        end
        MCH_PUSH: begin
          tbl_head_push     = 1'b1;
          tbl_head_push_tbl = mch_tbl;
          state_d           = S_SETTLE;
        end
        MCH_REPLACE: begin
          tbl_head_pop = 1'b1;
          repl_tbl_d   = mch_tbl;
          state_d      = S_REPL;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      repl_tbl_d = repl_tbl_q;
    end

    // Drain first so a cancel firing in the same cycle can reload the slot.
    if (rsp_vld_q && rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end else begin
      rsp_vld_d = rsp_vld_q;
    end

    if (ing_rdy) begin
      age_d = '0;
      if (ing_op_s == ING_INSERT) begin
        tbl_insert     = 1'b1;
        tbl_insert_tbl = ing_tbl;
      end else begin
        tbl_cancel     = 1'b1;
        tbl_cancel_uid = ing_uid;
        rsp_vld_d      = 1'b1;
        rsp_hit_d      = tbl_cancel_hit_w;
        rsp_tbl_d      = tbl_cancel_hit_w ? tbl_cancel_hit_tbl_w : '0;
      end
    end else if (ing_vld && (age_q != AGE_LIM)) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end
  end

  // State, age, table status and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      age_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_tbl_q  <= '0;
      repl_tbl_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      full_q     <= tbl_full_w;
      empty_q    <= tbl_empty_w;
      rsp_vld_q  <= rsp_vld_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_tbl_q  <= rsp_tbl_d;
      repl_tbl_q <= repl_tbl_d;
      run_q      <= 1'b1;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_tbl = rsp_tbl_q;
  assign busy    = (state_q != S_IDLE) | rsp_vld_q;

endmodule

// File: tb/tb_ob_tbl_sched.sv
// Scoreboard bench for ob_tbl_sched: stimulus pushes expected table strobes
// and cancel responses into queues; a negedge monitor pops and compares.
module tb_ob_tbl_sched;
  import ob_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ing_vld, ing_rdy, ing_op;
  logic [TBL_W-1:0] ing_tbl;
  logic [UID_W-1:0] ing_uid;
  logic             mch_vld, mch_rdy;
  logic [1:0]       mch_op;
  logic [TBL_W-1:0] mch_tbl;
  logic             rsp_vld, rsp_rdy, rsp_hit;
  logic [TBL_W-1:0] rsp_tbl;
  logic             tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push;
  logic [TBL_W-1:0] tbl_insert_tbl, tbl_head_push_tbl;
  logic [UID_W-1:0] tbl_cancel_uid;
  logic             tbl_cancel_hit_w, tbl_full_w, tbl_empty_w;
  logic [TBL_W-1:0] tbl_cancel_hit_tbl_w;
  logic             busy;

  localparam logic [TBL_W-1:0] E_INS  = {8'd1, 16'd100, 16'd10};
  localparam logic [TBL_W-1:0] E_P    = {8'd2, 16'd101, 16'd20};
  localparam logic [TBL_W-1:0] E_I    = {8'd3, 16'd99,  16'd30};
  localparam logic [TBL_W-1:0] E_R    = {8'd4, 16'd98,  16'd40};
  localparam logic [TBL_W-1:0] E_J    = {8'd5, 16'd97,  16'd50};
  localparam logic [TBL_W-1:0] E_K    = {8'd6, 16'd96,  16'd60};
  localparam logic [TBL_W-1:0] E7     = {8'd7, 16'd102, 16'd70};
  localparam logic [TBL_W-1:0] E_JUNK = 40'hA5_A5A5_A5A5;

  localparam logic [3:0] K_INS = 4'b1000;
  localparam logic [3:0] K_CAN = 4'b0100;
  localparam logic [3:0] K_POP = 4'b0010;
  localparam logic [3:0] K_PSH = 4'b0001;

  typedef struct {
    int               cyc;
    logic [3:0]       strb;
    logic [TBL_W-1:0] ins;
    logic [UID_W-1:0] uid;
    logic [TBL_W-1:0] psh;
  } strb_exp_t;

  typedef struct {
    logic             hit;
    logic [TBL_W-1:0] tbl;
  } rsp_exp_t;

  strb_exp_t sq[$];
  rsp_exp_t  rq[$];
  int        checks = 0;
  int        fails  = 0;
  int        cyc    = 0;

  // Table model: only uid 7 is present; misses return junk the DUT must zero.
  assign tbl_cancel_hit_w     = (tbl_cancel_uid == 8'd7);
  assign tbl_cancel_hit_tbl_w = tbl_cancel_hit_w ? E7 : E_JUNK;

  ob_tbl_sched #(.AGE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ing_vld(ing_vld), .ing_rdy(ing_rdy), .ing_op(ing_op),
    .ing_tbl(ing_tbl), .ing_uid(ing_uid),
    .mch_vld(mch_vld), .mch_rdy(mch_rdy), .mch_op(mch_op), .mch_tbl(mch_tbl),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit), .rsp_tbl(rsp_tbl),
    .tbl_insert(tbl_insert), .tbl_insert_tbl(tbl_insert_tbl),
    .tbl_cancel(tbl_cancel), .tbl_cancel_uid(tbl_cancel_uid),
    .tbl_head_pop(tbl_head_pop), .tbl_head_push(tbl_head_push),
    .tbl_head_push_tbl(tbl_head_push_tbl),
    .tbl_cancel_hit_w(tbl_cancel_hit_w),
    .tbl_cancel_hit_tbl_w(tbl_cancel_hit_tbl_w),
    .tbl_full_w(tbl_full_w), .tbl_empty_w(tbl_empty_w),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_strb(input logic [3:0] s, input logic [TBL_W-1:0] ins,
                          input logic [UID_W-1:0] uid, input logic [TBL_W-1:0] psh);
    strb_exp_t e;
    e.cyc = cyc; e.strb = s; e.ins = ins; e.uid = uid; e.psh = psh;
    sq.push_back(e);
  endtask

  task automatic exp_rsp(input logic hit, input logic [TBL_W-1:0] tbl);
    rsp_exp_t e;
    e.hit = hit; e.tbl = tbl;
    rq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  strb_exp_t  me;
  rsp_exp_t   mr;
  logic [3:0] ms;

  // Monitor: compares every table strobe and every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      ms = {tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push};
      if (ms != 4'b0000) begin
        check("strobe_onehot", 128'($countones(ms)), 128'(1));
        if (sq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got %b required none (cycle %0d)", ms, cyc);
        end else begin
          me = sq.pop_front();
          check("strobe_cycle", 128'(cyc), 128'(me.cyc));
          check("strobe_kind", 128'(ms), 128'(me.strb));
          check("strobe_payload", {tbl_insert_tbl, tbl_cancel_uid, tbl_head_push_tbl},
                {me.ins, me.uid, me.psh});
        end
      end
      if (rsp_vld && rsp_rdy) begin
        if (rq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp: got hit=%b tbl=%0h required none", rsp_hit, rsp_tbl);
        end else begin
          mr = rq.pop_front();
          check("rsp_payload", {rsp_hit, rsp_tbl}, {mr.hit, mr.tbl});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_rdy = 1'b0; tbl_full_w = 1'b0; tbl_empty_w = 1'b1;
    ing_vld = 1'b1; ing_op = ING_INSERT; ing_tbl = E_INS; ing_uid = 8'd0;
    mch_vld = 1'b1; mch_op = MCH_POP; mch_tbl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ing_rdy", 128'(ing_rdy), 128'(0));
    check("reset_mch_rdy", 128'(mch_rdy), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_rsp", {rsp_vld, rsp_hit, rsp_tbl}, 128'(0));
    check("reset_tbl", {tbl_insert, tbl_cancel, tbl_head_pop, tbl_head_push,
                        tbl_insert_tbl, tbl_cancel_uid, tbl_head_push_tbl}, 128'(0));
    ing_vld = 1'b0; mch_vld = 1'b0;
    rst_n = 1'b1;
    step(); step();

    // Empty table holds POP; INSERT goes through and unblocks it next cycle.
    mch_vld = 1'b1; mch_op = MCH_POP;
    #1 check("pop_on_empty_held", 128'(mch_rdy), 128'(0));
    step();
    ing_vld = 1'b1; ing_op = ING_INSERT; ing_tbl = E_INS; tbl_empty_w = 1'b0;
    exp_strb(K_INS, E_INS, '0, '0);
    #1 check("insert_rdy", {ing_rdy, mch_rdy}, 128'(2'b10));
    step();
    ing_vld = 1'b0; tbl_empty_w = 1'b1;
    exp_strb(K_POP, '0, '0, '0);
    #1 check("pop_after_insert", 128'(mch_rdy), 128'(1));
    step();
    mch_vld = 1'b0;
    #1 check("settle_busy", 128'(busy), 128'(1));
    step();
    check("idle_busy", 128'(busy), 128'(0));

    // PUSH beats a young ingress; ingress slips in during the settle cycle.
    mch_vld = 1'b1; mch_op = MCH_PUSH; mch_tbl = E_P;
    ing_vld = 1'b1; ing_op = ING_INSERT; ing_tbl = E_I;
    exp_strb(K_PSH, '0, '0, E_P);
    #1 check("match_wins", {ing_rdy, mch_rdy}, 128'(2'b01));
    step();
    exp_strb(K_INS, E_I, '0, '0);
    #1 check("settle_ingress", {ing_rdy, mch_rdy}, 128'(2'b10));
    step();
    ing_vld = 1'b0;
    exp_strb(K_PSH, '0, '0, E_P);
    step();
    mch_vld = 1'b0;
    step();

    // CANCEL hit, then a second CANCEL stalled behind the undrained response.
    ing_vld = 1'b1; ing_op = ING_CANCEL; ing_uid = 8'd7; rsp_rdy = 1'b0;
    exp_strb(K_CAN, '0, 8'd7, '0);
    exp_rsp(1'b1, E7);
    #1 check("cancel_rdy", {ing_rdy, rsp_vld}, 128'(2'b10));
    step();
    ing_uid = 8'd9;
    #1 check("rsp_hit_uid", {rsp_vld, rsp_hit, rsp_tbl[TBL_W-1 -: UID_W]}, {2'b11, 8'd7});
    check("cancel2_held", 128'(ing_rdy), 128'(0));
    step();
    for (int i = 0; i < 3; i++) begin
      check("cancel2_still_held", 128'(ing_rdy), 128'(0));
      step();
    end
    // Ingress has now stalled AGE_MAX cycles, so it beats a competing PUSH.
    rsp_rdy = 1'b1; mch_vld = 1'b1; mch_op = MCH_PUSH; mch_tbl = E_P;
    exp_strb(K_CAN, '0, 8'd9, '0);
    exp_rsp(1'b0, '0);
    #1 check("aged_ingress_wins", {ing_rdy, mch_rdy}, 128'(2'b10));
    step();
    ing_vld = 1'b0;
    exp_strb(K_PSH, '0, '0, E_P);
    #1 check("match_after_age", 128'(mch_rdy), 128'(1));
    step();
    mch_vld = 1'b0; rsp_rdy = 1'b0; tbl_empty_w = 1'b0;
    #1 check("rsp_drained", 128'(rsp_vld), 128'(0));
    step();

    // REPLACE: pop, push captured entry, settle; ingress locked out two cycles.
    mch_vld = 1'b1; mch_op = MCH_REPLACE; mch_tbl = E_R;
    ing_vld = 1'b1; ing_op = ING_INSERT; ing_tbl = E_J;
    exp_strb(K_POP, '0, '0, '0);
    #1 check("repl_c0_ing_rdy", 128'(ing_rdy), 128'(0));
    step();
    mch_vld = 1'b0; mch_tbl = E_JUNK;
    exp_strb(K_PSH, '0, '0, E_R);
    #1 check("repl_c1_locked", {ing_rdy, mch_rdy, busy}, 128'(3'b001));
    step();
    exp_strb(K_INS, E_J, '0, '0);
    #1 check("repl_c2_ingress", 128'(ing_rdy), 128'(1));
    step();
    ing_vld = 1'b0; tbl_full_w = 1'b1;
    step();

    // Full table: INSERT and PUSH held; POP frees it and INSERT follows.
    ing_vld = 1'b1; ing_op = ING_INSERT; ing_tbl = E_K;
    mch_vld = 1'b1; mch_op = MCH_PUSH; mch_tbl = E_P;
    #1 check("full_held_0", {ing_rdy, mch_rdy}, 128'(0));
    step();
    check("full_held_1", {ing_rdy, mch_rdy}, 128'(0));
    step();
    mch_op = MCH_POP;
    exp_strb(K_POP, '0, '0, '0);
    #1 check("full_pop", {ing_rdy, mch_rdy}, 128'(2'b01));
    step();
    mch_vld = 1'b0; tbl_full_w = 1'b0;
    #1 check("full_insert_wait", 128'(ing_rdy), 128'(0));
    step();
    exp_strb(K_INS, E_K, '0, '0);
    #1 check("full_insert_go", 128'(ing_rdy), 128'(1));
    step();
    ing_vld = 1'b0;
    step();

    // Reset in the middle of REPLACE drops the pending push.
    mch_vld = 1'b1; mch_op = MCH_REPLACE; mch_tbl = E_R;
    exp_strb(K_POP, '0, '0, '0);
    step();
    mch_vld = 1'b0;
    rst_n = 1'b0;
    #1 check("mid_repl_reset_outputs",
             {ing_rdy, mch_rdy, busy, rsp_vld, tbl_insert, tbl_cancel,
              tbl_head_pop, tbl_head_push, tbl_head_push_tbl}, 128'(0));
    step();
    rst_n = 1'b1;
    step(); step(); step();
    check("post_reset_idle", 128'(busy), 128'(0));

    check("strobe_queue_empty", 128'(sq.size()), 128'(0));
    check("rsp_queue_empty", 128'(rq.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
